// File: rtl/pipe_adder_seg_pkg.sv
// Shared definitions for the segmented pipelined adder: mode encoding and the full-adder cell.
package pipe_adder_seg_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Returns {carry_out, sum} of a one-bit full adder.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/pipe_adder_seg_if.sv
// Operand/result handshake bundle for pipe_adder_seg; master drives operands, slave returns results.
interface pipe_adder_seg_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cy;
  logic             ovf;

  modport master (
    output in_valid, A, B, Cin, mode, out_ready,
    input  in_ready, out_valid, sum, cy, ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, mode, out_ready,
    output in_ready, out_valid, sum, cy, ovf
  );
endinterface

// File: rtl/adder_seg.sv
// Combinational SEG-bit ripple-carry adder built from full-adder cells.
module adder_seg
  import pipe_adder_seg_pkg::*;
#(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);
  logic [SEG:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SEG; i++) begin : g_fa
    assign {c[i+1], s[i]} = full_add(a[i], b[i], c[i]);
  end

  assign co    = c[SEG];
  // Carry into the top bit of the segment, needed for signed overflow at the MSB stage.
  assign c_msb = c[SEG-1];
endmodule

// File: rtl/pipe_adder_seg.sv
// Pipelined add/subtract unit: one SEG-bit segment per stage, skewed operands, optional saturation.
module pipe_adder_seg
  import pipe_adder_seg_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 8,
  parameter int unsigned SAT   = 0
) (
  input logic            clk,
  input logic            rst,
  pipe_adder_seg_if.slave bus
);
  localparam int unsigned N  = WIDTH / SEG;
  localparam int unsigned NR = (N > 1) ? N - 1 : 1;

  logic advance;

  // Stage-k inputs: operands (B already inverted for subtract), carry, partial result, valid.
  logic [WIDTH-1:0] st_a   [N];
  logic [WIDTH-1:0] st_b   [N];
  logic [WIDTH-1:0] st_res [N];
  logic             st_c   [N];
  logic             st_v   [N];

  // Inter-stage registers: r_*[k] is the output of stage k feeding stage k+1.
  logic [WIDTH-1:0] r_a   [NR];
  logic [WIDTH-1:0] r_b   [NR];
  logic [WIDTH-1:0] r_res [NR];
  logic             r_c   [NR];
  logic             r_v   [NR];

  logic [SEG-1:0]   seg_s    [N];
  logic             seg_co   [N];
  logic             seg_cmsb [N];

  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] sat_sum;
  logic             raw_ovf;

  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  assign st_a[0]   = bus.A;
  assign st_b[0]   = (bus.mode == MODE_SUB) ? ~bus.B : bus.B;
  assign st_c[0]   = (bus.mode == MODE_ADD) ? bus.Cin : 1'b1;
  assign st_res[0] = '0;
  assign st_v[0]   = bus.in_valid;

  for (genvar k = 0; k < N; k++) begin : g_stage
    adder_seg #(.SEG(SEG)) u_adder (
      .a     (st_a[k][k*SEG +: SEG]),
      .b     (st_b[k][k*SEG +: SEG]),
      .ci    (st_c[k]),
      .s     (seg_s[k]),
      .co    (seg_co[k]),
      .c_msb (seg_cmsb[k])
    );

    if (k > 0) begin : g_feed
      assign st_a[k]   = r_a[k-1];
      assign st_b[k]   = r_b[k-1];
      assign st_res[k] = r_res[k-1];
      assign st_c[k]   = r_c[k-1];
      assign st_v[k]   = r_v[k-1];
    end

    if (k < N - 1) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          r_v[k]   <= 1'b0;
          r_a[k]   <= '0;
          r_b[k]   <= '0;
          r_res[k] <= '0;
          r_c[k]   <= 1'b0;
        end else if (advance) begin
          r_v[k]   <= st_v[k];
          r_a[k]   <= st_a[k];
          r_b[k]   <= st_b[k];
          // Segment k of the partial result is still zero here, so OR-ing inserts it.
          r_res[k] <= st_res[k] | (WIDTH'(seg_s[k]) << (k*SEG));
          r_c[k]   <= seg_co[k];
        end
      end
    end
  end

  assign raw_sum = st_res[N-1] | (WIDTH'(seg_s[N-1]) << ((N-1)*SEG));
  assign raw_ovf = seg_co[N-1] ^ seg_cmsb[N-1];
  assign sat_sum = st_a[N-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

  // Final stage registers the outputs; data only changes when a real beat lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.sum       <= '0;
      bus.cy        <= 1'b0;
      bus.ovf       <= 1'b0;
    end else if (advance) begin
      bus.out_valid <= st_v[N-1];
      if (st_v[N-1]) begin
        bus.sum <= ((SAT != 0) && raw_ovf) ? sat_sum : raw_sum;
        bus.cy  <= seg_co[N-1];
        bus.ovf <= raw_ovf;
      end
    end
  end
endmodule

// File: tb/tb_pipe_adder_seg.sv
// Directed and random checks of pipe_adder_seg across several WIDTH/SEG/SAT configurations.
module tb_pipe_adder_seg;
  import pipe_adder_seg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_adder_seg_if #(.WIDTH(16)) bus16  ();
  pipe_adder_seg_if #(.WIDTH(16)) bus16s ();
  pipe_adder_seg_if #(.WIDTH(32)) bus32  ();
  pipe_adder_seg_if #(.WIDTH(8))  bus8   ();

  pipe_adder_seg #(.WIDTH(16), .SEG(8), .SAT(0)) u16  (.clk(clk), .rst(rst), .bus(bus16));
  pipe_adder_seg #(.WIDTH(16), .SEG(8), .SAT(1)) u16s (.clk(clk), .rst(rst), .bus(bus16s));
  pipe_adder_seg #(.WIDTH(32), .SEG(8), .SAT(0)) u32  (.clk(clk), .rst(rst), .bus(bus32));
  pipe_adder_seg #(.WIDTH(8),  .SEG(8), .SAT(0)) u8   (.clk(clk), .rst(rst), .bus(bus8));

  // Directed vectors: mode, A, B, Cin -> sum (SAT=0), cy, ovf, sum (SAT=1)
  localparam logic        VM  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [15:0] VA  [8] = '{16'h00FF, 16'hFFFF, 16'h0005, 16'h7FFF, 16'h8000, 16'h1234, 16'h0010, 16'h8000};
  localparam logic [15:0] VB  [8] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0001, 16'h4321, 16'h0010, 16'h8000};
  localparam logic        VCI [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [15:0] VS  [8] = '{16'h0100, 16'h0000, 16'hFFFE, 16'h8000, 16'h7FFF, 16'h5556, 16'h0000, 16'h0000};
  localparam logic        VC  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam logic        VO  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [15:0] VSS [8] = '{16'h0100, 16'h0000, 16'hFFFE, 16'h7FFF, 16'h8000, 16'h5556, 16'h0000, 16'h8000};

  // Back-to-back stream beats
  localparam logic        BM  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [15:0] BA  [6] = '{16'h0001, 16'h00FF, 16'h1000, 16'hFFFF, 16'h1234, 16'h0000};
  localparam logic [15:0] BB  [6] = '{16'h0002, 16'h0001, 16'h0001, 16'h0001, 16'h1111, 16'h0001};
  localparam logic        BCI [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [15:0] BS  [6] = '{16'h0003, 16'h0100, 16'h0FFF, 16'h0000, 16'h2346, 16'hFFFF};
  localparam logic        BC  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  // Reference: returns {ovf, cy, sum}; overflow from operand/result signs.
  function automatic logic [33:0] model32(input logic m, input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [31:0] bb;
    logic [32:0] full;
    bb   = (m == MODE_SUB) ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 33'((m == MODE_SUB) ? 1'b1 : ci);
    return {(a[31] == bb[31]) && (full[31] != a[31]), full[32], full[31:0]};
  endfunction

  function automatic logic [9:0] model8(input logic m, input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [7:0] bb;
    logic [8:0] full;
    bb   = (m == MODE_SUB) ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 9'((m == MODE_SUB) ? 1'b1 : ci);
    return {(a[7] == bb[7]) && (full[7] != a[7]), full[8], full[7:0]};
  endfunction

  task automatic idle_all();
    bus16.in_valid = 1'b0;  bus16.A = '0;  bus16.B = '0;  bus16.Cin = 1'b0;  bus16.mode = MODE_ADD;  bus16.out_ready = 1'b1;
    bus16s.in_valid = 1'b0; bus16s.A = '0; bus16s.B = '0; bus16s.Cin = 1'b0; bus16s.mode = MODE_ADD; bus16s.out_ready = 1'b1;
    bus32.in_valid = 1'b0;  bus32.A = '0;  bus32.B = '0;  bus32.Cin = 1'b0;  bus32.mode = MODE_ADD;  bus32.out_ready = 1'b1;
    bus8.in_valid = 1'b0;   bus8.A = '0;   bus8.B = '0;   bus8.Cin = 1'b0;   bus8.mode = MODE_ADD;   bus8.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus16.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", bus16.out_valid); end
    checks++; if (bus16.sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got %h exp 0000", bus16.sum); end
    checks++; if (bus16.cy !== 1'b0 || bus16.ovf !== 1'b0) begin errors++; $display("FAIL reset_flags got cy=%0b ovf=%0b exp 0 0", bus16.cy, bus16.ovf); end
    checks++; if (bus32.out_valid !== 1'b0 || bus8.out_valid !== 1'b0 || bus16s.out_valid !== 1'b0) begin errors++; $display("FAIL reset_other_valid got %0b%0b%0b exp 000", bus32.out_valid, bus8.out_valid, bus16s.out_valid); end
    rst = 1'b0;
    #1;
    checks++; if (bus16.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", bus16.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    for (int i = 0; i < 8; i++) begin
      bus16.mode = VM[i];  bus16.A = VA[i];  bus16.B = VB[i];  bus16.Cin = VCI[i];  bus16.in_valid = 1'b1;
      bus16s.mode = VM[i]; bus16s.A = VA[i]; bus16s.B = VB[i]; bus16s.Cin = VCI[i]; bus16s.in_valid = 1'b1;
      @(posedge clk); #1;
      bus16.in_valid = 1'b0; bus16s.in_valid = 1'b0;
      checks++; if (bus16.out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_early_valid got %0b exp 0", i, bus16.out_valid); end
      @(posedge clk); #1;
      checks++; if (bus16.out_valid !== 1'b1) begin errors++; $display("FAIL vec%0d_latency got %0b exp 1", i, bus16.out_valid); end
      checks++; if (bus16.sum !== VS[i]) begin errors++; $display("FAIL vec%0d_sum got %h exp %h", i, bus16.sum, VS[i]); end
      checks++; if (bus16.cy !== VC[i] || bus16.ovf !== VO[i]) begin errors++; $display("FAIL vec%0d_flags got cy=%0b ovf=%0b exp %0b %0b", i, bus16.cy, bus16.ovf, VC[i], VO[i]); end
      checks++; if (bus16s.sum !== VSS[i]) begin errors++; $display("FAIL vec%0d_sat_sum got %h exp %h", i, bus16s.sum, VSS[i]); end
      checks++; if (bus16s.cy !== VC[i] || bus16s.ovf !== VO[i]) begin errors++; $display("FAIL vec%0d_sat_flags got cy=%0b ovf=%0b exp %0b %0b", i, bus16s.cy, bus16s.ovf, VC[i], VO[i]); end
    end
    @(posedge clk); #1;
    checks++; if (bus16.out_valid !== 1'b0 || bus16.sum !== VS[7]) begin errors++; $display("FAIL vec_hold got valid=%0b sum=%h exp 0 %h", bus16.out_valid, bus16.sum, VS[7]); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int recv = 0;
    for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      bus16.out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 6) begin
        bus16.in_valid = 1'b1; bus16.mode = BM[sent]; bus16.A = BA[sent]; bus16.B = BB[sent]; bus16.Cin = BCI[sent];
      end else begin
        bus16.in_valid = 1'b0;
      end
      #1;
      if (cyc >= 3 && cyc <= 5) begin
        checks++; if (bus16.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready cyc%0d got %0b exp 0", cyc, bus16.in_ready); end
        checks++; if (bus16.out_valid !== 1'b1 || bus16.sum !== BS[recv]) begin errors++; $display("FAIL b2b_stall_hold cyc%0d got valid=%0b sum=%h exp 1 %h", cyc, bus16.out_valid, bus16.sum, BS[recv]); end
      end
      if (bus16.out_valid && bus16.out_ready) begin
        checks++; if (bus16.sum !== BS[recv] || bus16.cy !== BC[recv]) begin errors++; $display("FAIL b2b_result%0d got sum=%h cy=%0b exp %h %0b", recv, bus16.sum, bus16.cy, BS[recv], BC[recv]); end
        recv++;
      end
      if (bus16.in_valid && bus16.in_ready) sent++;
      @(posedge clk); #1;
    end
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b1;
    checks++; if (recv !== 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", recv); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    bus16.out_ready = 1'b1;
    bus16.mode = MODE_ADD; bus16.A = 16'h1111; bus16.B = 16'h2222; bus16.Cin = 1'b0; bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.A = 16'h0F0F; bus16.B = 16'h0101;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; rst = 1'b1;
    checks++; if (bus16.out_valid !== 1'b1 || bus16.sum !== 16'h3333) begin errors++; $display("FAIL rstmid_pre got valid=%0b sum=%h exp 1 3333", bus16.out_valid, bus16.sum); end
    @(posedge clk); #1;
    rst = 1'b0; bus16.out_ready = 1'b1;
    #1;
    checks++; if (bus16.out_valid !== 1'b0 || bus16.sum !== 16'h0000) begin errors++; $display("FAIL rstmid_clear got valid=%0b sum=%h exp 0 0000", bus16.out_valid, bus16.sum); end
    checks++; if (bus16.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %0b exp 1", bus16.in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (bus16.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale cyc%0d got %0b exp 0", i, bus16.out_valid); end
    end
    bus16.A = 16'h0101; bus16.B = 16'h0202; bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    checks++; if (bus16.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_fresh_early got %0b exp 0", bus16.out_valid); end
    @(posedge clk); #1;
    checks++; if (bus16.out_valid !== 1'b1 || bus16.sum !== 16'h0303) begin errors++; $display("FAIL rstmid_fresh got valid=%0b sum=%h exp 1 0303", bus16.out_valid, bus16.sum); end
  endtask

  task automatic test_random();
    logic [33:0] q32[$];
    logic [9:0]  q8[$];
    logic [33:0] e32;
    logic [9:0]  e8;
    for (int cyc = 0; cyc < 340 && (cyc < 300 || q32.size() > 0 || q8.size() > 0); cyc++) begin
      bus32.out_ready = (cyc >= 300) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      bus8.out_ready  = (cyc >= 300) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
      bus32.in_valid  = (cyc < 300) && ($urandom_range(0, 3) != 0);
      bus8.in_valid   = (cyc < 300) && ($urandom_range(0, 1) != 0);
      bus32.A = $urandom; bus32.B = $urandom; bus32.mode = 1'($urandom); bus32.Cin = 1'($urandom);
      bus8.A = 8'($urandom); bus8.B = 8'($urandom); bus8.mode = 1'($urandom); bus8.Cin = 1'($urandom);
      #1;
      if (bus32.in_valid && bus32.in_ready) q32.push_back(model32(bus32.mode, bus32.A, bus32.B, bus32.Cin));
      if (bus8.in_valid && bus8.in_ready) q8.push_back(model8(bus8.mode, bus8.A, bus8.B, bus8.Cin));
      if (bus32.out_valid && bus32.out_ready) begin
        e32 = (q32.size() > 0) ? q32.pop_front() : 34'h3_FFFF_FFFF;
        checks++; if ({bus32.ovf, bus32.cy, bus32.sum} !== e32) begin errors++; $display("FAIL rand32 cyc%0d got ovf=%0b cy=%0b sum=%h exp %h", cyc, bus32.ovf, bus32.cy, bus32.sum, e32); end
      end
      if (bus8.out_valid && bus8.out_ready) begin
        e8 = (q8.size() > 0) ? q8.pop_front() : 10'h3FF;
        checks++; if ({bus8.ovf, bus8.cy, bus8.sum} !== e8) begin errors++; $display("FAIL rand8 cyc%0d got ovf=%0b cy=%0b sum=%h exp %h", cyc, bus8.ovf, bus8.cy, bus8.sum, e8); end
      end
      @(posedge clk); #1;
    end
    bus32.in_valid = 1'b0; bus8.in_valid = 1'b0;
    checks++; if (q32.size() != 0 || q8.size() != 0) begin errors++; $display("FAIL rand_drain got pending32=%0d pending8=%0d exp 0 0", q32.size(), q8.size()); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_adder_seg.md
PIPE_ADDER_SEG -- requirements
Module: pipe_adder_seg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter SEG, default 8, meaning segment width per pipeline stage; WIDTH must be an integer multiple of SEG.
REQ-003 The block SHALL have parameter SAT, default 0, meaning that 1 enables signed saturation of the result.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  operand beat is valid.
REQ-007 in_ready  output  1  block accepts an operand beat this cycle.
REQ-008 A  input  WIDTH  operand A.
REQ-009 B  input  WIDTH  operand B.
REQ-010 Cin  input  1  carry-in; used in add mode only.
REQ-011 mode  input  1  operation select: 0 = add, 1 = subtract.
REQ-012 out_valid  output  1  result beat is valid.
REQ-013 out_ready  input  1  downstream accepts the result beat.
REQ-014 sum  output  WIDTH  result.
REQ-015 cy  output  1  carry-out of the MSB; in subtract mode, 1 means no borrow.
REQ-016 ovf  output  1  two's-complement signed overflow of the unsaturated result.

Function
REQ-017 The block SHALL define the stage count as N = WIDTH/SEG, with segment k covering bits [k*SEG+SEG-1 : k*SEG].
REQ-018 Add mode SHALL compute A + B + Cin; subtract mode SHALL compute A + ~B + 1 and ignore Cin.
REQ-019 Stage k SHALL add segment k of both operands, taking its carry-in from the carry registered in stage k-1; stage 0 SHALL take its carry-in from Cin or from 1 in subtract mode.
REQ-020 Upper operand segments SHALL be delayed by k register stages, and lower result segments SHALL be delayed so that all segments align at the output.
REQ-021 Handshake: a beat SHALL transfer on in_valid & in_ready at the input and on out_valid & out_ready at the output.
REQ-022 The block SHALL define advance = !out_valid | out_ready; all pipeline registers, including the per-stage valid bits, SHALL load only when advance is 1.
REQ-023 in_ready SHALL equal advance, combinationally.
REQ-024 Latency from input transfer to out_valid SHALL be exactly N cycles when there is no backpressure; throughput SHALL be one beat per cycle.
REQ-025 Under a stall (out_valid=1, out_ready=0), sum, cy, ovf and out_valid SHALL hold stable, and no beat SHALL be lost, duplicated or reordered.
REQ-026 Accepting a new beat while the output beat is draining in the same cycle SHALL be legal and SHALL lose nothing.
REQ-027 ovf SHALL be 1 when the MSB carry-in differs from the MSB carry-out.
REQ-028 With SAT=1 and ovf=1, sum SHALL be 0x7F..F when A[MSB]=0 and 0x80..0 when A[MSB]=1.
REQ-029 With SAT=1, cy and ovf SHALL still report the raw, unsaturated values.
REQ-030 With N=1, the block SHALL behave as a single registered adder with latency 1.
REQ-031 Data outputs SHALL be don't-care-free: they hold the last transferred value while out_valid=0.

Reset
REQ-032 When rst=1 at a clock edge, all stage valid bits and out_valid SHALL clear to 0, and sum, cy and ovf SHALL clear to 0.
REQ-033 A reset mid-stream SHALL discard every in-flight beat with no partial result emitted.
REQ-034 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-035 A shared package SHALL hold the mode encoding constants (MODE_ADD=0, MODE_SUB=1).
REQ-036 The combinational SEG-bit ripple-carry adder SHALL be a sub-module named adder_seg, built from full-adder cells, with N instances generated.
REQ-037 The pipeline, skew/deskew registers, handshake logic and saturation logic SHALL reside in pipe_adder_seg.

Verification (WIDTH=16, SEG=8 unless noted)
REQ-038 add 0x00FF+0x0001, Cin=0 -> sum=0x0100, cy=0, ovf=0; out_valid asserts exactly 2 cycles after the transfer.
REQ-039 add 0xFFFF+0x0001 -> sum=0x0000, cy=1, ovf=0; subtract 0x0005-0x0007 -> sum=0xFFFE, cy=0, ovf=0.
REQ-040 add 0x7FFF+0x0001 -> SAT=0: sum=0x8000, ovf=1; SAT=1: sum=0x7FFF, ovf=1; subtract 0x8000-0x0001 with SAT=1 -> sum=0x8000, ovf=1.
REQ-041 Back-to-back stream of 6 beats with out_ready held low for 3 cycles mid-stream -> in_ready low during the stall, outputs stable, all 6 results emitted in order.
REQ-042 Assert rst with 2 beats in flight -> out_valid=0 and sum=0 next cycle, no stale beat emitted, and a fresh beat after reset returns a correct result at latency 2.
REQ-043 Random add/sub traffic with random valid/ready for WIDTH=32/SEG=8 and WIDTH=8/SEG=8 -> every result matches the reference model.
